// File: rtl/ethpipe_rx_slots_if.sv
`default_nettype none
// ============================================================================
// Module      : ethpipe_rx_slots_if
// Description : Bundle of the GMII receive inputs, the frame-RAM write port,
//               the per-frame completion record and the slot bookkeeping
//               signals of the ethpipe slot receiver.
//   master : receiver side (consumes GMII/timestamp/release, drives RAM
//            writes, completion record, occupancy and drop counter)
//   slave  : surrounding system side (the mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
interface ethpipe_rx_slots_if #(
    parameter int BYTES     = 2,
    parameter int SLOT_BITS = 2,
    parameter int WORD_AW   = 11,
    parameter int LEN_W     = 12
) ();
    logic [63:0]                  global_counter;
    logic [7:0]                   gmii_rxd;
    logic                         gmii_rx_dv;
    logic                         gmii_rx_er;
    logic                         slot_wr_en;
    logic [SLOT_BITS+WORD_AW-1:0] slot_wr_addr;
    logic [8*BYTES-1:0]           slot_wr_data;
    logic [BYTES-1:0]             slot_wr_be;
    logic                         done_valid;
    logic [SLOT_BITS-1:0]         done_slot;
    logic [LEN_W-1:0]             done_len;
    logic [63:0]                  done_ts;
    logic                         done_err;
    logic                         done_trunc;
    logic                         slot_release;
    logic [SLOT_BITS:0]           slots_used;
    logic [31:0]                  drop_count;

    modport master (
        input  global_counter, gmii_rxd, gmii_rx_dv, gmii_rx_er, slot_release,
        output slot_wr_en, slot_wr_addr, slot_wr_data, slot_wr_be,
        output done_valid, done_slot, done_len, done_ts, done_err, done_trunc,
        output slots_used, drop_count
    );

    modport slave (
        output global_counter, gmii_rxd, gmii_rx_dv, gmii_rx_er, slot_release,
        input  slot_wr_en, slot_wr_addr, slot_wr_data, slot_wr_be,
        input  done_valid, done_slot, done_len, done_ts, done_err, done_trunc,
        input  slots_used, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/ethpipe_rx_slots.sv
`default_nettype none
// ============================================================================
// Module      : ethpipe_rx_slots
// Description : GMII receive engine that stores each frame into one of
//               NUM_SLOTS ring-buffer slots of a shared frame RAM and reports
//               per-frame metadata (length, first-byte timestamp, error and
//               truncation flags). Frames arriving with every slot occupied
//               are dropped and counted.
// Ports       : gmii_rx_clk - receive clock (single clock domain)
//               sys_rst     - asynchronous active-high reset
//               rx_if       - master side of ethpipe_rx_slots_if (GMII in,
//                             RAM write port, completion record, slot
//                             release / occupancy, drop counter)
// Revision    : 1.0 - initial release
// ============================================================================
module ethpipe_rx_slots #(
    parameter int BYTES     = 2,
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_BITS = 2,
    parameter int WORD_AW   = 11,
    parameter int HDR_WORDS = 2,
    parameter int LEN_W     = 12,
    parameter int MAX_LEN   = 2048
) (
    input  wire logic          gmii_rx_clk,
    input  wire logic          sys_rst,
    ethpipe_rx_slots_if.master rx_if
);

    localparam int               c_lane_bits = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LEN_W-1:0] c_max_len   = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_WAIT_IFG = 2'd0,
        S_IDLE     = 2'd1,
        S_RECV     = 2'd2,
        S_DISCARD  = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic                         r_wr_en;
    logic [SLOT_BITS+WORD_AW-1:0] r_wr_addr;
    logic [8*BYTES-1:0]           r_wr_data;
    logic [BYTES-1:0]             r_wr_be;
    logic                         r_done_valid;
    logic [SLOT_BITS-1:0]         r_done_slot;
    logic [LEN_W-1:0]             r_done_len;
    logic [63:0]                  r_done_ts;
    logic                         r_done_err;
    logic                         r_done_trunc;
    logic [SLOT_BITS:0]           r_slots_used;
    logic [31:0]                  r_drop_count;
    logic [SLOT_BITS-1:0]         r_wr_ptr;
    logic [LEN_W-1:0]             r_len;
    logic [63:0]                  r_ts;
    logic                         r_err;
    logic                         r_trunc;

    logic                         w_dv;
    logic                         w_full;
    logic                         w_start;
    logic                         w_drop;
    logic                         w_recv_dv;
    logic                         w_take;
    logic                         w_end;
    logic                         w_rel;
    logic [LEN_W-1:0]             w_n;
    logic [c_lane_bits-1:0]       w_lane;
    logic [WORD_AW-1:0]           w_word;

    assign w_dv = rx_if.gmii_rx_dv;

    // A completion record issued last cycle has not reached r_slots_used yet
    // (occupancy follows done_valid by one cycle so that a release coinciding
    // with done_valid nets to zero), so it is counted here as already taken.
    assign w_full    = ({1'b0, r_slots_used} + (SLOT_BITS+2)'(r_done_valid))
                       >= (SLOT_BITS+2)'(NUM_SLOTS);
    assign w_start   = (r_state == S_IDLE) && w_dv && !w_full;
    assign w_drop    = (r_state == S_IDLE) && w_dv && w_full;
    assign w_recv_dv = (r_state == S_RECV) && w_dv;
    assign w_take    = w_start || (w_recv_dv && (r_len < c_max_len));
    assign w_end     = (r_state == S_RECV) && !w_dv;
    assign w_rel     = rx_if.slot_release && (r_slots_used != '0);

    // Index of the byte on the bus this cycle: 0 when a frame is starting,
    // otherwise the number of bytes already stored.
    assign w_n    = (r_state == S_IDLE) ? '0 : r_len;
    assign w_lane = c_lane_bits'(w_n % BYTES);
    assign w_word = WORD_AW'(HDR_WORDS) + WORD_AW'(w_n / BYTES);

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_WAIT_IFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Never lock onto a frame already in flight when reset ends.
            S_WAIT_IFG: if (!w_dv) w_state_nxt = S_IDLE;
            S_IDLE:     if (w_dv)  w_state_nxt = w_full ? S_DISCARD : S_RECV;
            S_RECV:     if (!w_dv) w_state_nxt = S_IDLE;
            S_DISCARD:  if (!w_dv) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_WAIT_IFG;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: RAM write port, frame accumulation, completion, bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_be      <= '0;
            r_done_valid <= 1'b0;
            r_done_slot  <= '0;
            r_done_len   <= '0;
            r_done_ts    <= '0;
            r_done_err   <= 1'b0;
            r_done_trunc <= 1'b0;
            r_slots_used <= '0;
            r_drop_count <= '0;
            r_wr_ptr     <= '0;
            r_len        <= '0;
            r_ts         <= '0;
            r_err        <= 1'b0;
            r_trunc      <= 1'b0;
        end else begin
            r_wr_en <= w_take;
            if (w_take) begin
                r_wr_addr <= {r_wr_ptr, w_word};
                r_wr_be   <= BYTES'(1) << w_lane;
                r_wr_data <= (8*BYTES)'(rx_if.gmii_rxd) << {w_lane, 3'b000};
            end

            if (w_start) begin
                r_len   <= LEN_W'(1);
                r_ts    <= rx_if.global_counter;
                r_err   <= rx_if.gmii_rx_er;
                r_trunc <= 1'b0;
            end else if (w_recv_dv) begin
                if (r_len < c_max_len) begin
                    r_len <= r_len + LEN_W'(1);
                end else begin
                    r_trunc <= 1'b1;
                end
                if (rx_if.gmii_rx_er) begin
                    r_err <= 1'b1;
                end
            end

            r_done_valid <= w_end;
            if (w_end) begin
                r_done_slot  <= r_wr_ptr;
                r_done_len   <= r_len;
                r_done_ts    <= r_ts;
                r_done_err   <= r_err;
                r_done_trunc <= r_trunc;
                r_wr_ptr     <= r_wr_ptr + SLOT_BITS'(1);
            end

            case ({r_done_valid, w_rel})
                2'b10:   r_slots_used <= r_slots_used + (SLOT_BITS+1)'(1);
                2'b01:   r_slots_used <= r_slots_used - (SLOT_BITS+1)'(1);
                default: r_slots_used <= r_slots_used;
            endcase

            if (w_drop && (r_drop_count != 32'hFFFF_FFFF)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign rx_if.slot_wr_en   = r_wr_en;
    assign rx_if.slot_wr_addr = r_wr_addr;
    assign rx_if.slot_wr_data = r_wr_data;
    assign rx_if.slot_wr_be   = r_wr_be;
    assign rx_if.done_valid   = r_done_valid;
    assign rx_if.done_slot    = r_done_slot;
    assign rx_if.done_len     = r_done_len;
    assign rx_if.done_ts      = r_done_ts;
    assign rx_if.done_err     = r_done_err;
    assign rx_if.done_trunc   = r_done_trunc;
    assign rx_if.slots_used   = r_slots_used;
    assign rx_if.drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_ethpipe_rx_slots.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethpipe_rx_slots
// Description : Directed self-checking bench for ethpipe_rx_slots (default
//               parameters: 2 bytes/word, 4 slots, 2 header words,
//               MAX_LEN 2048).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethpipe_rx_slots;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ethpipe_rx_slots_if #(.BYTES(2), .SLOT_BITS(2), .WORD_AW(11), .LEN_W(12)) bus ();

    ethpipe_rx_slots #(
        .BYTES(2), .NUM_SLOTS(4), .SLOT_BITS(2), .WORD_AW(11),
        .HDR_WORDS(2), .LEN_W(12), .MAX_LEN(2048)
    ) dut (
        .gmii_rx_clk (clk),
        .sys_rst     (rst),
        .rx_if       (bus)
    );

    // Write / completion recorder
    int          wr_total = 0;
    int          done_total = 0;
    logic [12:0] wr_addr_q [0:8191];
    logic [15:0] wr_data_q [0:8191];
    logic [1:0]  wr_be_q   [0:8191];
    int          wr_cyc_q  [0:8191];

    always @(negedge clk) begin
        if (bus.slot_wr_en === 1'b1) begin
            if (wr_total < 8192) begin
                wr_addr_q[wr_total] = bus.slot_wr_addr;
                wr_data_q[wr_total] = bus.slot_wr_data;
                wr_be_q[wr_total]   = bus.slot_wr_be;
                wr_cyc_q[wr_total]  = cyc;
            end
            wr_total++;
        end
        if (bus.done_valid === 1'b1) done_total++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic pulse_release();
        @(negedge clk);
        bus.slot_release = 1'b1;
        @(negedge clk);
        bus.slot_release = 1'b0;
    endtask

    // Byte i carries value i mod 256 and timestamp ts0+i; returns with dv
    // just dropped.
    task automatic send_frame(input int len, input logic [63:0] ts0, input int er_at,
                              output int start_cyc);
        start_cyc = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            bus.gmii_rx_dv     = 1'b1;
            bus.gmii_rxd       = i[7:0];
            bus.gmii_rx_er     = (i == er_at);
            bus.global_counter = ts0 + 64'(i);
        end
        @(negedge clk);
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
    endtask

    task automatic test_reset();
        bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0; bus.gmii_rxd = 8'h00;
        bus.global_counter = 64'd0; bus.slot_release = 1'b0;
        rst = 1'b1;
        idle(3);
        checks++; if (bus.slot_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0h exp 0", bus.slot_wr_en); end
        checks++; if (bus.slot_wr_addr !== 13'h0) begin errors++; $display("FAIL reset_wr_addr got %0h exp 0", bus.slot_wr_addr); end
        checks++; if (bus.slot_wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", bus.slot_wr_data); end
        checks++; if (bus.slot_wr_be !== 2'b00) begin errors++; $display("FAIL reset_wr_be got %0h exp 0", bus.slot_wr_be); end
        checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %0h exp 0", bus.done_valid); end
        checks++; if (bus.done_slot !== 2'd0) begin errors++; $display("FAIL reset_done_slot got %0h exp 0", bus.done_slot); end
        checks++; if (bus.done_len !== 12'd0) begin errors++; $display("FAIL reset_done_len got %0h exp 0", bus.done_len); end
        checks++; if (bus.done_ts !== 64'd0) begin errors++; $display("FAIL reset_done_ts got %0h exp 0", bus.done_ts); end
        checks++; if (bus.done_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %0h exp 0", bus.done_err); end
        checks++; if (bus.done_trunc !== 1'b0) begin errors++; $display("FAIL reset_done_trunc got %0h exp 0", bus.done_trunc); end
        checks++; if (bus.slots_used !== 3'd0) begin errors++; $display("FAIL reset_slots_used got %0h exp 0", bus.slots_used); end
        checks++; if (bus.drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count got %0h exp 0", bus.drop_count); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_frame();
        int w0, d0, sc;
        w0 = wr_total; d0 = done_total;
        send_frame(64, 64'd100, -1, sc);
        idle(3);
        checks++; if (wr_total - w0 !== 64) begin errors++; $display("FAIL basic_wr_count got %0d exp 64", wr_total - w0); end
        checks++; if (wr_cyc_q[w0] !== sc + 1) begin errors++; $display("FAIL basic_latency_first got %0d exp %0d", wr_cyc_q[w0], sc + 1); end
        checks++; if (wr_cyc_q[w0+63] !== sc + 64) begin errors++; $display("FAIL basic_latency_last got %0d exp %0d", wr_cyc_q[w0+63], sc + 64); end
        checks++; if ({wr_addr_q[w0], wr_be_q[w0], wr_data_q[w0]} !== {13'h0002, 2'b01, 16'h0000}) begin errors++; $display("FAIL basic_byte0 got addr %0h be %0h data %0h exp 2/1/0000", wr_addr_q[w0], wr_be_q[w0], wr_data_q[w0]); end
        checks++; if ({wr_addr_q[w0+1], wr_be_q[w0+1], wr_data_q[w0+1]} !== {13'h0002, 2'b10, 16'h0100}) begin errors++; $display("FAIL basic_byte1 got addr %0h be %0h data %0h exp 2/2/0100", wr_addr_q[w0+1], wr_be_q[w0+1], wr_data_q[w0+1]); end
        checks++; if ({wr_addr_q[w0+63], wr_be_q[w0+63], wr_data_q[w0+63]} !== {13'h0021, 2'b10, 16'h3F00}) begin errors++; $display("FAIL basic_byte63 got addr %0h be %0h data %0h exp 21/2/3f00", wr_addr_q[w0+63], wr_be_q[w0+63], wr_data_q[w0+63]); end
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_total - d0); end
        checks++; if (bus.done_len !== 12'd64) begin errors++; $display("FAIL basic_done_len got %0d exp 64", bus.done_len); end
        checks++; if (bus.done_ts !== 64'd100) begin errors++; $display("FAIL basic_done_ts got %0d exp 100", bus.done_ts); end
        checks++; if (bus.done_slot !== 2'd0) begin errors++; $display("FAIL basic_done_slot got %0d exp 0", bus.done_slot); end
        checks++; if ({bus.done_err, bus.done_trunc} !== 2'b00) begin errors++; $display("FAIL basic_flags got %0b exp 00", {bus.done_err, bus.done_trunc}); end
        checks++; if (bus.slots_used !== 3'd1) begin errors++; $display("FAIL basic_slots_used got %0d exp 1", bus.slots_used); end
    endtask

    task automatic test_fill_and_drop();
        int w0, d0, sc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_frame(60, 64'(200 + 100*k), -1, sc);
            idle(3);
            checks++; if (bus.done_slot !== 2'(k)) begin errors++; $display("FAIL fill_done_slot%0d got %0d exp %0d", k, bus.done_slot, k); end
        end
        checks++; if (bus.slots_used !== 3'd4) begin errors++; $display("FAIL fill_slots_used got %0d exp 4", bus.slots_used); end
        w0 = wr_total; d0 = done_total;
        send_frame(60, 64'd700, -1, sc);
        idle(3);
        checks++; if (wr_total - w0 !== 0) begin errors++; $display("FAIL drop_writes got %0d exp 0", wr_total - w0); end
        checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL drop_done got %0d exp 0", done_total - d0); end
        checks++; if (bus.drop_count !== 32'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", bus.drop_count); end
        pulse_release();
        idle(1);
        checks++; if (bus.slots_used !== 3'd3) begin errors++; $display("FAIL release_slots_used got %0d exp 3", bus.slots_used); end
        w0 = wr_total; d0 = done_total;
        send_frame(60, 64'd800, -1, sc);
        idle(3);
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL sixth_done got %0d exp 1", done_total - d0); end
        checks++; if (bus.done_slot !== 2'd0) begin errors++; $display("FAIL sixth_done_slot got %0d exp 0", bus.done_slot); end
        checks++; if (wr_addr_q[w0] !== 13'h0002) begin errors++; $display("FAIL sixth_first_addr got %0h exp 2", wr_addr_q[w0]); end
        checks++; if (bus.done_ts !== 64'd800) begin errors++; $display("FAIL sixth_done_ts got %0d exp 800", bus.done_ts); end
    endtask

    task automatic test_truncation();
        int w0, sc;
        do_reset();
        w0 = wr_total;
        send_frame(3000, 64'd5000, -1, sc);
        idle(3);
        checks++; if (wr_total - w0 !== 2048) begin errors++; $display("FAIL trunc_wr_count got %0d exp 2048", wr_total - w0); end
        checks++; if ({wr_addr_q[w0+2047], wr_be_q[w0+2047], wr_data_q[w0+2047]} !== {13'h0401, 2'b10, 16'hFF00}) begin errors++; $display("FAIL trunc_last_write got addr %0h be %0h data %0h exp 401/2/ff00", wr_addr_q[w0+2047], wr_be_q[w0+2047], wr_data_q[w0+2047]); end
        checks++; if (wr_cyc_q[w0+2047] !== sc + 2048) begin errors++; $display("FAIL trunc_last_cycle got %0d exp %0d", wr_cyc_q[w0+2047], sc + 2048); end
        checks++; if (bus.done_len !== 12'd2048) begin errors++; $display("FAIL trunc_done_len got %0d exp 2048", bus.done_len); end
        checks++; if (bus.done_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag got %0b exp 1", bus.done_trunc); end
        checks++; if (bus.done_err !== 1'b0) begin errors++; $display("FAIL trunc_err got %0b exp 0", bus.done_err); end
    endtask

    task automatic test_rx_error();
        int w0, sc;
        do_reset();
        w0 = wr_total;
        send_frame(100, 64'd9000, 50, sc);
        idle(3);
        checks++; if (wr_total - w0 !== 100) begin errors++; $display("FAIL err_wr_count got %0d exp 100", wr_total - w0); end
        checks++; if (bus.done_err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b exp 1", bus.done_err); end
        checks++; if (bus.done_len !== 12'd100) begin errors++; $display("FAIL err_done_len got %0d exp 100", bus.done_len); end
        checks++; if (bus.done_trunc !== 1'b0) begin errors++; $display("FAIL err_trunc got %0b exp 0", bus.done_trunc); end
        send_frame(10, 64'd9500, -1, sc);
        idle(3);
        checks++; if ({bus.done_err, bus.done_slot, bus.done_len} !== {1'b0, 2'd1, 12'd10}) begin errors++; $display("FAIL err_cleared got err %0b slot %0d len %0d exp 0/1/10", bus.done_err, bus.done_slot, bus.done_len); end
    endtask

    task automatic test_release_edges();
        int sc;
        do_reset();
        send_frame(20, 64'd300, -1, sc); idle(3);
        send_frame(20, 64'd400, -1, sc); idle(3);
        checks++; if (bus.slots_used !== 3'd2) begin errors++; $display("FAIL rel_pre_used got %0d exp 2", bus.slots_used); end
        send_frame(20, 64'd500, -1, sc);
        @(negedge clk);
        checks++; if ({bus.done_valid, bus.slots_used} !== {1'b1, 3'd2}) begin errors++; $display("FAIL rel_done_cycle got valid %0b used %0d exp 1/2", bus.done_valid, bus.slots_used); end
        bus.slot_release = 1'b1;
        @(negedge clk);
        bus.slot_release = 1'b0;
        checks++; if ({bus.done_valid, bus.slots_used} !== {1'b0, 3'd2}) begin errors++; $display("FAIL rel_coincide got valid %0b used %0d exp 0/2", bus.done_valid, bus.slots_used); end
        pulse_release();
        pulse_release();
        checks++; if (bus.slots_used !== 3'd0) begin errors++; $display("FAIL rel_drain got %0d exp 0", bus.slots_used); end
        pulse_release();
        idle(1);
        checks++; if (bus.slots_used !== 3'd0) begin errors++; $display("FAIL rel_at_zero got %0d exp 0", bus.slots_used); end
    endtask

    task automatic test_reset_midframe();
        int w0, d0, sc;
        w0 = wr_total; d0 = done_total;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.gmii_rx_dv     = 1'b1;
            bus.gmii_rxd       = i[7:0];
            bus.gmii_rx_er     = 1'b0;
            bus.global_counter = 64'(1000 + i);
            if (i == 30) begin
                #2 rst = 1'b1;
            end
            if (i == 31) begin
                checks++; if ({bus.slot_wr_en, bus.slot_wr_addr, bus.slot_wr_data, bus.slot_wr_be} !== 32'd0) begin errors++; $display("FAIL midrst_wr_port got en %0b addr %0h data %0h be %0h exp 0", bus.slot_wr_en, bus.slot_wr_addr, bus.slot_wr_data, bus.slot_wr_be); end
                checks++; if ({bus.done_slot, bus.done_len, bus.done_ts, bus.slots_used} !== 81'd0) begin errors++; $display("FAIL midrst_status got slot %0d len %0d ts %0d used %0d exp 0", bus.done_slot, bus.done_len, bus.done_ts, bus.slots_used); end
            end
            if (i == 32) rst = 1'b0;
        end
        @(negedge clk);
        bus.gmii_rx_dv = 1'b0;
        idle(3);
        checks++; if (wr_total - w0 !== 30) begin errors++; $display("FAIL midrst_writes got %0d exp 30", wr_total - w0); end
        checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", done_total - d0); end
        w0 = wr_total;
        send_frame(20, 64'd2000, -1, sc);
        idle(3);
        checks++; if ({bus.done_slot, bus.done_len, bus.done_ts} !== {2'd0, 12'd20, 64'd2000}) begin errors++; $display("FAIL midrst_next got slot %0d len %0d ts %0d exp 0/20/2000", bus.done_slot, bus.done_len, bus.done_ts); end
        checks++; if (wr_addr_q[w0] !== 13'h0002) begin errors++; $display("FAIL midrst_next_addr got %0h exp 2", wr_addr_q[w0]); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_fill_and_drop();
        test_truncation();
        test_rx_error();
        test_release_edges();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ethpipe_rx_slots.md
Name: ethpipe_rx_slots

Overview:
- Next-generation GMII receive engine for the ethpipe core.
- Writes each received frame into one of NUM_SLOTS ring-buffer slots of a shared frame RAM, using a parametrised data width.
- Reports per-frame metadata: length, timestamp, error and truncation flags.
- Single clock domain (gmii_rx_clk). The host side frees slots through a pulse that is already synchronised to gmii_rx_clk. Frames arriving with no free slot are dropped and counted.

Parameters:
- BYTES, 2: bytes per RAM word. Power of two, 1..8.
- NUM_SLOTS, 4: number of frame slots. Power of two, >= 2.
- SLOT_BITS, 2: log2(NUM_SLOTS).
- WORD_AW, 11: word-address bits within one slot.
- HDR_WORDS, 2: words reserved at the start of each slot. Payload begins at word HDR_WORDS.
- LEN_W, 12: width of frame-length fields.
- MAX_LEN, 2048: maximum bytes stored per frame. Requirement: HDR_WORDS + ceil(MAX_LEN/BYTES) <= 2^WORD_AW.

Ports:
- gmii_rx_clk, in, 1: receive clock.
- sys_rst, in, 1: asynchronous, active-high reset.
- global_counter, in, 64: free-running timestamp source.
- gmii_rxd, in, 8: GMII receive data.
- gmii_rx_dv, in, 1: GMII receive data valid.
- gmii_rx_er, in, 1: GMII receive error.
- slot_wr_en, out, 1: RAM write strobe.
- slot_wr_addr, out, SLOT_BITS+WORD_AW: RAM word address, formed as {slot, word}.
- slot_wr_data, out, 8*BYTES: RAM write data.
- slot_wr_be, out, BYTES: RAM byte enables.
- done_valid, out, 1: one-cycle pulse when a frame has been stored.
- done_slot, out, SLOT_BITS: slot index of the completed frame.
- done_len, out, LEN_W: stored byte count.
- done_ts, out, 64: timestamp of the first byte.
- done_err, out, 1: gmii_rx_er was seen during the frame.
- done_trunc, out, 1: frame exceeded MAX_LEN.
- slot_release, in, 1: pulse; host has freed the oldest used slot.
- slots_used, out, SLOT_BITS+1: number of occupied slots.
- drop_count, out, 32: saturating count of frames dropped for lack of a slot.

Behaviour:
- Reset: all outputs 0. Write slot pointer 0. State WAIT_IFG.
- State WAIT_IFG: go to IDLE on the first cycle with dv=0. This prevents capturing a frame mid-stream after reset.
- State IDLE, on a cycle with dv=1 and slots_used < NUM_SLOTS:
  - go to RECV;
  - this cycle's byte is byte 0;
  - latch ts = global_counter; clear the err and trunc flags.
- State IDLE, on a cycle with dv=1 and slots_used == NUM_SLOTS:
  - go to DISCARD;
  - increment drop_count, saturating at 0xFFFFFFFF;
  - no writes.
- State RECV, per byte n sampled with dv=1 (n counts from 0; byte 0 is the one accepted in IDLE):
  - If n < MAX_LEN, the next cycle shows: slot_wr_en=1; slot_wr_addr={wr_ptr, HDR_WORDS + n/BYTES}; slot_wr_be one-hot at lane n%BYTES; slot_wr_data = the byte in that lane, zeros elsewhere. Write latency is exactly 1 cycle.
  - If n >= MAX_LEN: no write, set trunc, hold the length at MAX_LEN.
  - gmii_rx_er=1 on any dv cycle sets err.
  - slot_wr_en is 0 on every cycle that does not follow an accepted byte.
- End of frame, on the first dv=0 cycle in RECV:
  - next cycle: done_valid=1 for one cycle, with done_slot=wr_ptr, done_len=min(bytes, MAX_LEN), done_ts, done_err, done_trunc;
  - wr_ptr advances mod NUM_SLOTS; slots_used increments;
  - go to IDLE. A new frame may start on the cycle after dv=0.
- State DISCARD: return to IDLE on dv=0.
- done_* fields other than done_valid hold their values until the next completion.
- slots_used arithmetic:
  - completion and slot_release in the same cycle: net change 0;
  - slot_release with slots_used == 0: ignored;
  - slot_release during RECV: counted normally, and the current frame is unaffected.
- Wrap-around:
  - wr_ptr goes from NUM_SLOTS-1 to 0;
  - the word address never exceeds HDR_WORDS + (MAX_LEN-1)/BYTES.
- Reset asserted mid-frame: immediate clear, no done_valid, back to WAIT_IFG.
- Slot availability is checked only at frame start. A release that arrives during DISCARD does not revive the dropped frame.

Test Plan:
- Defaults; 64-byte frame of bytes 0x00..0x3F, ts=100 at byte 0:
  - 64 writes, 1 cycle after each byte;
  - byte 0 at addr {0,2} with be=01, data 0x0000; byte 1 at addr {0,2} with be=10, data 0x0100;
  - done_len=64, done_ts=100, done_slot=0.
- Four 60-byte frames with no release: done_slot 0,1,2,3 and slots_used=4. A fifth frame gives no writes, no done_valid, and drop_count=1. After one slot_release, a sixth frame lands in slot 0.
- MAX_LEN=2048 with a 3000-byte frame:
  - the last write is at word 2+1023;
  - done_len=2048, done_trunc=1.
- A 100-byte frame with gmii_rx_er=1 at byte 50: all 100 bytes written, done_err=1.
- slot_release coincides with a done_valid cycle at slots_used=2: slots_used stays 2. slot_release at slots_used=0: stays 0.
- sys_rst asserted at byte 30 and released while dv is still 1: no writes until dv falls. The next frame goes to slot 0 and all outputs are 0 after reset.
